// File: rtl/mux3_bus_arbiter_pkg.sv
// mux3_bus_arbiter_pkg: shared select codes, FSM states and helpers for the 3-way bus arbiter.
package mux3_bus_arbiter_pkg;
   localparam logic [1:0] SEL_R0   = 2'b00;
   localparam logic [1:0] SEL_R1   = 2'b01;
   localparam logic [1:0] SEL_R2   = 2'b10;
   localparam logic [1:0] SEL_IDLE = 2'b11;

   typedef enum logic {ST_IDLE, ST_GRANT} state_t;

   function automatic logic [2:0] onehot3(input logic [1:0] sel);
      return sel == SEL_R0 ? 3'b001 : sel == SEL_R1 ? 3'b010 : sel == SEL_R2 ? 3'b100 : 3'b000;
   endfunction

   function automatic logic [1:0] rr_next(input logic [1:0] x);
      return x >= 2'd2 ? 2'd0 : x + 2'd1;
   endfunction
endpackage

// File: rtl/mux3_bus_arbiter_rr_pick3.sv
// rr_pick3: combinational round-robin picker, searching from ptr+1 and wrapping back to ptr.
module rr_pick3
   import mux3_bus_arbiter_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic       found,
   output logic [1:0] win
);
   logic [1:0] c1, c2;
   always_comb begin
      c1    = rr_next(ptr);
      c2    = rr_next(c1);
      found = |req;
      win   = req[c1] ? c1 : req[c2] ? c2 : ptr;
   end
endmodule

// File: rtl/mux3_bus_arbiter.sv
// mux3_bus_arbiter: round-robin owner of the shared 4-bit 3:1 mux, with burst, back-pressure and beat-limit release.
module mux3_bus_arbiter
   import mux3_bus_arbiter_pkg::*;
#(
   parameter int MAX_BEATS = 4,
   parameter int CNT_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       req,
   input  logic [2:0]       last,
   input  logic             ready,
   output logic [1:0]       sel,
   output logic [2:0]       gnt,
   output logic             busy,
   output logic             xfer,
   output logic [CNT_W-1:0] beats
);
   state_t           state_q, state_d;
   logic [1:0]       sel_q, sel_d, ptr_q, ptr_d, pick_ptr, win;
   logic [2:0]       gnt_q, gnt_d;
   logic [CNT_W-1:0] beats_q, beats_d;
   logic             own_req, own_last, at_limit, rel, arb, found;

   rr_pick3 u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (found),
      .win   (win)
   );

   // gnt_q is one-hot on the owner, so masking selects the owner's bits without indexing by sel
   always_comb begin
      own_req  = |(req & gnt_q);
      own_last = |(last & gnt_q);
      xfer     = (state_q == ST_GRANT) & ready & own_req;
      at_limit = (MAX_BEATS != 0) && (int'(beats_q) + 1 == MAX_BEATS);
      rel      = (state_q == ST_GRANT) & (~own_req | (xfer & own_last) | (xfer & at_limit));
      arb      = (state_q == ST_IDLE) | rel;
      pick_ptr = rel ? sel_q : ptr_q;
      ptr_d    = pick_ptr;
      state_d  = arb ? (found ? ST_GRANT : ST_IDLE) : state_q;
      sel_d    = arb ? (found ? win : SEL_IDLE) : sel_q;
      gnt_d    = onehot3(sel_d);
      beats_d  = arb ? '0 : beats_q + CNT_W'(xfer);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sel_q   <= SEL_IDLE;
         gnt_q   <= '0;
         beats_q <= '0;
         ptr_q   <= 2'd2;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         beats_q <= beats_d;
         ptr_q   <= ptr_d;
      end
   end

   assign sel   = sel_q;
   assign gnt   = gnt_q;
   assign busy  = state_q == ST_GRANT;
   assign beats = beats_q;
endmodule

// File: tb/tb_mux3_bus_arbiter.sv
// tb_mux3_bus_arbiter: table vectors, corner sequences and random traffic against an owner/pointer reference model.
module tb_mux3_bus_arbiter;
   localparam int MAX_BEATS = 4;
   localparam int CNT_W     = 3;

   logic             clk = 1'b0;
   logic             rst, ready, busy, xfer;
   logic [2:0]       req, last, gnt;
   logic [1:0]       sel;
   logic [CNT_W-1:0] beats;

   int vectors = 0;
   int errors  = 0;
   int m_owner = -1;
   int m_ptr   = 2;
   int m_beats = 0;
   bit m_valid = 1'b0;

   typedef struct {
      logic       r;
      logic [2:0] rq, l;
      logic       rd;
      int         sel, gnt, busy, beats, xf;
   } vec_t;
   vec_t tbl[24];

   mux3_bus_arbiter #(.MAX_BEATS(MAX_BEATS), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .last  (last),
      .ready (ready),
      .sel   (sel),
      .gnt   (gnt),
      .busy  (busy),
      .xfer  (xfer),
      .beats (beats)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask

   // Reference: owner index (-1 idle), last-owner pointer and beat count, updated per edge
   function automatic void model_edge();
      bit x, rel;
      x = m_owner >= 0 && ready && req[m_owner];
      if (rst) begin
         m_owner = -1;
         m_ptr   = 2;
         m_beats = 0;
         m_valid = 1'b1;
         return;
      end
      if (m_owner >= 0) begin
         rel = !req[m_owner] || (x && last[m_owner]) || (x && MAX_BEATS != 0 && m_beats + 1 == MAX_BEATS);
         if (!rel) begin
            m_beats = (m_beats + int'(x)) % (1 << CNT_W);
            return;
         end
         m_ptr = m_owner;
      end
      m_owner = -1;
      m_beats = 0;
      for (int k = 1; k <= 3; k++) begin
         if (req[(m_ptr + k) % 3]) begin
            m_owner = (m_ptr + k) % 3;
            break;
         end
      end
   endfunction

   task automatic cyc(input logic r, input logic [2:0] rq, input logic [2:0] l, input logic rd);
      rst = r; req = rq; last = l; ready = rd;
      #1;
      if (m_valid) begin
         chk("sel", 32'(sel), m_owner < 0 ? 32'd3 : 32'(m_owner));
         chk("gnt", 32'(gnt), m_owner < 0 ? 32'd0 : 32'(1 << m_owner));
         chk("busy", 32'(busy), 32'(m_owner >= 0));
         chk("beats", 32'(beats), 32'(m_beats));
         chk("xfer", 32'(xfer), 32'(m_owner >= 0 && rd && rq[m_owner]));
      end
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 3'b111, 3'b000, 1'b1, 3, 0, 0, 0, 0};
      tbl[1]  = '{1'b0, 3'b111, 3'b000, 1'b1, 3, 0, 0, 0, 0};
      tbl[2]  = '{1'b0, 3'b001, 3'b000, 1'b0, 0, 1, 1, 0, 0};
      tbl[3]  = '{1'b0, 3'b000, 3'b000, 1'b0, 0, 1, 1, 0, 0};
      tbl[4]  = '{1'b0, 3'b010, 3'b000, 1'b1, 3, 0, 0, 0, 0};
      tbl[5]  = '{1'b0, 3'b010, 3'b000, 1'b1, 1, 2, 1, 0, 1};
      tbl[6]  = '{1'b0, 3'b010, 3'b000, 1'b1, 1, 2, 1, 1, 1};
      tbl[7]  = '{1'b0, 3'b010, 3'b010, 1'b1, 1, 2, 1, 2, 1};
      tbl[8]  = '{1'b0, 3'b000, 3'b000, 1'b1, 1, 2, 1, 0, 0};
      tbl[9]  = '{1'b0, 3'b111, 3'b111, 1'b1, 3, 0, 0, 0, 0};
      tbl[10] = '{1'b0, 3'b111, 3'b111, 1'b1, 2, 4, 1, 0, 1};
      tbl[11] = '{1'b0, 3'b111, 3'b111, 1'b1, 0, 1, 1, 0, 1};
      tbl[12] = '{1'b0, 3'b111, 3'b111, 1'b1, 1, 2, 1, 0, 1};
      tbl[13] = '{1'b0, 3'b111, 3'b111, 1'b1, 2, 4, 1, 0, 1};
      tbl[14] = '{1'b0, 3'b111, 3'b111, 1'b1, 0, 1, 1, 0, 1};
      tbl[15] = '{1'b0, 3'b011, 3'b000, 1'b1, 1, 2, 1, 0, 1};
      tbl[16] = '{1'b0, 3'b011, 3'b000, 1'b1, 1, 2, 1, 1, 1};
      tbl[17] = '{1'b0, 3'b011, 3'b000, 1'b1, 1, 2, 1, 2, 1};
      tbl[18] = '{1'b0, 3'b011, 3'b000, 1'b1, 1, 2, 1, 3, 1};
      tbl[19] = '{1'b0, 3'b011, 3'b000, 1'b1, 0, 1, 1, 0, 1};
      tbl[20] = '{1'b0, 3'b011, 3'b000, 1'b1, 0, 1, 1, 1, 1};
      tbl[21] = '{1'b0, 3'b011, 3'b000, 1'b1, 0, 1, 1, 2, 1};
      tbl[22] = '{1'b0, 3'b011, 3'b000, 1'b1, 0, 1, 1, 3, 1};
      tbl[23] = '{1'b0, 3'b011, 3'b000, 1'b1, 1, 2, 1, 0, 1};
      rst = 1'b1; req = '0; last = '0; ready = 1'b0;
      @(negedge clk);
      cyc(1'b1, 3'b111, 3'b000, 1'b1);
      for (int i = 0; i < 24; i++) begin
         rst = tbl[i].r; req = tbl[i].rq; last = tbl[i].l; ready = tbl[i].rd;
         #1;
         chk("tbl_sel", 32'(sel), tbl[i].sel);
         chk("tbl_gnt", 32'(gnt), tbl[i].gnt);
         chk("tbl_busy", 32'(busy), tbl[i].busy);
         chk("tbl_beats", 32'(beats), tbl[i].beats);
         chk("tbl_xfer", 32'(xfer), tbl[i].xf);
         cyc(tbl[i].r, tbl[i].rq, tbl[i].l, tbl[i].rd);
      end
      cyc(1'b0, 3'b000, 3'b000, 1'b1);
      cyc(1'b0, 3'b100, 3'b000, 1'b1);
      cyc(1'b0, 3'b100, 3'b000, 1'b1);
      cyc(1'b0, 3'b100, 3'b000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1'b0, 3'b100, 3'b100, 1'b0);
         chk("bp_sel", 32'(sel), 32'd2);
         chk("bp_beats", 32'(beats), 32'd2);
      end
      cyc(1'b0, 3'b011, 3'b100, 1'b1);
      chk("abandon_sel", 32'(sel), 32'd0);
      chk("abandon_beats", 32'(beats), 32'd0);
      cyc(1'b0, 3'b010, 3'b000, 1'b0);
      cyc(1'b0, 3'b010, 3'b000, 1'b1);
      cyc(1'b0, 3'b010, 3'b000, 1'b1);
      chk("pre_rst_sel", 32'(sel), 32'd1);
      chk("pre_rst_beats", 32'(beats), 32'd2);
      cyc(1'b1, 3'b111, 3'b111, 1'b1);
      chk("mid_rst_sel", 32'(sel), 32'd3);
      chk("mid_rst_gnt", 32'(gnt), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_beats", 32'(beats), 32'd0);
      cyc(1'b0, 3'b111, 3'b000, 1'b1);
      chk("post_rst_sel", 32'(sel), 32'd0);
      chk("post_rst_gnt", 32'(gnt), 32'd1);
      for (int i = 0; i < 400; i++)
         cyc($urandom_range(0, 49) == 0, 3'($urandom),
             $urandom_range(0, 3) == 0 ? 3'($urandom) : 3'b000, $urandom_range(0, 3) != 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/mux3_bus_arbiter.md
Name: mux3_bus_arbiter

Overview:
- Round-robin arbiter/sequencer for the shared 4-bit 3-to-1 mux datapath.
- Three requesters compete for one 4-bit bus. The block drives the mux 2-bit select: 00/01/10 choose requester 0/1/2; 11 forces the output to zero (idle).
- Handles burst ownership, downstream back-pressure and a per-grant beat limit so no requester starves the others.

Parameters:
- MAX_BEATS, 4, maximum accepted beats per grant before forced release; 0 = unlimited.
- CNT_W, 3, beat-counter width; must satisfy 2**CNT_W > MAX_BEATS.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- req  in  3  per-requester request; bit i held high while requester i has data.
- last  in  3  per-requester end-of-burst flag; qualified only on the granted bit during a transfer.
- ready  in  1  downstream accepts the current bus word this cycle.
- sel  out  2  registered mux select; 11 when idle.
- gnt  out  3  registered one-hot grant; all zero when idle.
- busy  out  1  registered; 1 while any grant is active.
- xfer  out  1  combinational; high when busy & ready & req[owner] (beat accepted this cycle).
- beats  out  CNT_W  registered count of beats accepted in the current grant.

Behaviour:
- Arbitration rule:
  - Reset values: sel=11, gnt=000, busy=0, beats=0. Internal last-owner pointer ptr=2, so requester 0 has top priority first.
  - Candidates are searched starting at ptr+1 mod 3, wrapping, and the first requester found wins.
- States: IDLE and GRANT.
  - IDLE: if req!=000, pick a winner. Next cycle: GRANT, sel=winner, gnt=onehot(winner), busy=1, beats=0. Request-to-grant latency is 1 cycle. If req==000, stay in IDLE with outputs at their idle values.
  - GRANT, no release: on xfer, beats increments. Without xfer, all outputs hold (stall on ready=0 is unlimited).
- Release conditions, evaluated each cycle in GRANT, in priority order:
  - (a) req[owner]=0, i.e. abandon: release, no beat counted.
  - (b) xfer & last[owner].
  - (c) xfer & MAX_BEATS!=0 & beats+1==MAX_BEATS.
- On release:
  - ptr is set to the owner, and re-arbitration happens in the same cycle using the updated ptr.
  - If another requester (or the same one, when it is the only one) has req high after the edge, the next cycle is GRANT to the new winner with beats=0. There is no idle bubble.
  - Otherwise the next state is IDLE.
  - The released owner has the lowest priority for that re-arbitration.
- Boundary cases:
  - last asserted with ready=0: no transfer, no release.
  - Beat counter saturates logically via the release; it never wraps while MAX_BEATS!=0. With MAX_BEATS=0 it wraps modulo 2**CNT_W and is informational only.
  - sel and gnt always agree: sel=11 if and only if gnt=000 if and only if busy=0.
  - last bits of non-owners are ignored.
- Reset mid-grant: the next edge forces all reset values regardless of state or inputs. An in-flight burst is dropped.

Decomposition:
- Shared package:
  - SEL_R0=2'b00, SEL_R1=2'b01, SEL_R2=2'b10, SEL_IDLE=2'b11.
  - State encoding: ST_IDLE, ST_GRANT.
  - Function onehot3(sel).
- One natural sub-module: rr_pick3, a combinational round-robin picker.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: found, win[1:0].
  - Instantiated once; used by both the IDLE and release paths.

Test Plan:
- Reset: rst=1 for 2 cycles with req=111 -> sel=11, gnt=000, busy=0, beats=0. First cycle after rst falls -> still idle. Next cycle -> sel=00, gnt=001.
- Single burst: req=010, ready=1, last[1] set on the 3rd beat -> grant 1 cycle after req, beats counts 0,1,2, then IDLE with sel=11 one cycle after the last beat.
- Contention rotation: req=111 held, last pulsed on every beat, ready=1 -> sel sequence 00,01,10,00,01 with no idle cycles.
- Beat limit: MAX_BEATS=4, req=011, last=000, ready=1 -> owner 0 released after exactly 4 xfers, then sel=01 the next cycle.
- Back-pressure and abandon: owner 2 with ready=0 for 5 cycles -> outputs frozen, beats unchanged. Then req[2] drops -> release with no beat counted, and arbitration proceeds to any pending requester.
- Reset mid-grant: rst pulsed while sel=01 and beats=2 -> next cycle all reset values, and ptr=2 (requester 0 wins next).
